// File: rtl/strb2mask_pkg.sv
// Shared types and constants for the AXI write-strobe to chunk splitter.
package strb2mask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Chunk byte counts as presented on pmesh_data_size
    localparam logic [7:0] SZ_1B = 8'd1;
    localparam logic [7:0] SZ_2B = 8'd2;
    localparam logic [7:0] SZ_4B = 8'd4;
    localparam logic [7:0] SZ_8B = 8'd8;

    // Byte masks of a chunk at offset 0; bit 7 is byte offset 0
    localparam logic [7:0] BASE_1B = 8'b1000_0000;
    localparam logic [7:0] BASE_2B = 8'b1100_0000;
    localparam logic [7:0] BASE_4B = 8'b1111_0000;
    localparam logic [7:0] BASE_8B = 8'b1111_1111;

    // Place a base mask at byte offset addr (MSB-first, so shift right)
    function automatic logic [7:0] chunk_mask(input logic [7:0] base, input logic [2:0] addr);
        return base >> addr;
    endfunction

endpackage

// File: rtl/strb2mask_chunk_sel.sv
// Combinational greedy chunk picker: lowest set offset, then the largest
// naturally aligned power-of-two run of set bytes starting there.
module strb_chunk_sel
    import strb2mask_pkg::*;
(
    input  logic [7:0] i_mask,
    output logic [2:0] o_addr,
    output logic [7:0] o_size,
    output logic [7:0] o_clear
);

    logic       w_found;
    logic [2:0] w_addr;
    logic [7:0] w_m8;
    logic [7:0] w_m4;
    logic [7:0] w_m2;
    logic [7:0] w_m1;

    // Find the lowest byte offset still pending
    always_comb begin
        w_found = 1'b0;
        w_addr  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!w_found && i_mask[3'(7 - i)]) begin
                w_found = 1'b1;
                w_addr  = 3'(i);
            end
        end
    end

    assign w_m8 = chunk_mask(BASE_8B, w_addr);
    assign w_m4 = chunk_mask(BASE_4B, w_addr);
    assign w_m2 = chunk_mask(BASE_2B, w_addr);
    assign w_m1 = chunk_mask(BASE_1B, w_addr);

    // Pick the widest aligned fully-set chunk; all zeros when nothing pending
    always_comb begin
        o_addr  = '0;
        o_size  = '0;
        o_clear = '0;
        if (w_found) begin
            o_addr = w_addr;
            if (w_addr == 3'd0 && (i_mask & w_m8) == w_m8) begin
                o_size  = SZ_8B;
                o_clear = w_m8;
            end else if (w_addr[1:0] == 2'd0 && (i_mask & w_m4) == w_m4) begin
                o_size  = SZ_4B;
                o_clear = w_m4;
            end else if (w_addr[0] == 1'b0 && (i_mask & w_m2) == w_m2) begin
                o_size  = SZ_2B;
                o_clear = w_m2;
            end else begin
                o_size  = SZ_1B;
                o_clear = w_m1;
            end
        end
    end

endmodule

// File: rtl/strb2mask.sv
// Splits an 8-byte AXI write strobe into aligned power-of-two chunks,
// one chunk per downstream handshake.
module strb2mask
    import strb2mask_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] m_axi_wstrb,
    input  logic       s_channel_valid,
    output logic       s_channel_ready,
    output logic       d_channel_valid,
    input  logic       d_channel_ready,
    output logic [7:0] pmesh_data_size,
    output logic [2:0] pmesh_addr
);

    state_t     r_state;
    logic [7:0] r_mask;
    logic [2:0] w_addr;
    logic [7:0] w_size;
    logic [7:0] w_clear;
    logic [7:0] w_next_mask;

    strb_chunk_sel u_sel (
        .i_mask  (r_mask),
        .o_addr  (w_addr),
        .o_size  (w_size),
        .o_clear (w_clear)
    );

    assign w_next_mask = r_mask & ~w_clear;

    // Accept a strobe in IDLE, retire one chunk per d-handshake in SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_channel_valid) begin
                        r_mask  <= m_axi_wstrb;
                        r_state <= (m_axi_wstrb != 8'd0) ? SEND : IDLE;
                    end
                end
                SEND: begin
                    if (d_channel_ready) begin
                        r_mask  <= w_next_mask;
                        r_state <= (w_next_mask == 8'd0) ? IDLE : SEND;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_mask  <= '0;
                end
            endcase
        end
    end

    assign s_channel_ready = (r_state == IDLE);
    assign d_channel_valid = (r_state == SEND);
    assign pmesh_addr      = d_channel_valid ? w_addr : '0;
    assign pmesh_data_size = d_channel_valid ? w_size : '0;

endmodule

// File: tb/tb_strb2mask.sv
// Directed self-checking bench for strb2mask.
module tb_strb2mask;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_axi_wstrb;
    logic       s_channel_valid;
    logic       s_channel_ready;
    logic       d_channel_valid;
    logic       d_channel_ready;
    logic [7:0] pmesh_data_size;
    logic [2:0] pmesh_addr;

    int passed = 0;
    int total  = 0;

    strb2mask dut (
        .clk             (clk),
        .rst             (rst),
        .m_axi_wstrb     (m_axi_wstrb),
        .s_channel_valid (s_channel_valid),
        .s_channel_ready (s_channel_ready),
        .d_channel_valid (d_channel_valid),
        .d_channel_ready (d_channel_ready),
        .pmesh_data_size (pmesh_data_size),
        .pmesh_addr      (pmesh_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one strobe for exactly one handshake cycle (block assumed idle)
    task automatic load(input logic [7:0] s);
        m_axi_wstrb     = s;
        s_channel_valid = 1'b1;
        step();
        s_channel_valid = 1'b0;
        m_axi_wstrb     = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_channel_valid = 1'b0; m_axi_wstrb = 8'h00; d_channel_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        total++;
        if ({s_channel_ready, d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, 1'b0, 3'd0, 8'd0})
            $display("FAIL reset: rdy=%b vld=%b addr=%0d size=%0d, want 1 0 0 0",
                     s_channel_ready, d_channel_valid, pmesh_addr, pmesh_data_size);
        else passed++;
    endtask

    task automatic test_single();
        d_channel_ready = 1'b1;
        load(8'b1111_0000);
        total++;
        if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b1, 1'b0, 3'd0, 8'd4})
            $display("FAIL single_chunk: vld=%b rdy=%b addr=%0d size=%0d, want 1 0 0 4",
                     d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size);
        else passed++;
        step();
        total++;
        if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b0, 1'b1, 3'd0, 8'd0})
            $display("FAIL single_idle: vld=%b rdy=%b addr=%0d size=%0d, want 0 1 0 0",
                     d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size);
        else passed++;
    endtask

    task automatic test_multi();
        logic [2:0] ea[4] = '{3'd1, 3'd2, 3'd4, 3'd6};
        logic [7:0] es[4] = '{8'd1, 8'd2, 8'd2, 8'd1};
        d_channel_ready = 1'b1;
        load(8'b0111_1110);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, ea[i], es[i]})
                $display("FAIL multi_chunk%0d: vld=%b addr=%0d size=%0d, want 1 %0d %0d",
                         i, d_channel_valid, pmesh_addr, pmesh_data_size, ea[i], es[i]);
            else passed++;
            step();
        end
        total++;
        if ({d_channel_valid, s_channel_ready} !== 2'b01)
            $display("FAIL multi_idle: vld=%b rdy=%b, want 0 1", d_channel_valid, s_channel_ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ea[3] = '{3'd1, 3'd2, 3'd4};
        logic [7:0] es[3] = '{8'd1, 8'd2, 8'd4};
        d_channel_ready = 1'b1;
        load(8'b0111_1111);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, ea[i], es[i]})
                $display("FAIL b2b_chunk%0d: vld=%b addr=%0d size=%0d, want 1 %0d %0d",
                         i, d_channel_valid, pmesh_addr, pmesh_data_size, ea[i], es[i]);
            else passed++;
            step();
        end
        total++;
        if (s_channel_ready !== 1'b1)
            $display("FAIL b2b_ready: rdy=%b, want 1", s_channel_ready);
        else passed++;
        load(8'hFF);
        total++;
        if ({d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, 3'd0, 8'd8})
            $display("FAIL b2b_full: vld=%b addr=%0d size=%0d, want 1 0 8",
                     d_channel_valid, pmesh_addr, pmesh_data_size);
        else passed++;
        step();
        total++;
        if (d_channel_valid !== 1'b0)
            $display("FAIL b2b_full_done: vld=%b, want 0", d_channel_valid);
        else passed++;
    endtask

    task automatic test_stall();
        logic [2:0] ea[4] = '{3'd1, 3'd2, 3'd4, 3'd6};
        logic [7:0] es[4] = '{8'd1, 8'd2, 8'd2, 8'd1};
        d_channel_ready = 1'b0;
        load(8'b0111_1110);
        for (int i = 0; i < 4; i++) begin
            // A competing strobe during SEND must be ignored
            s_channel_valid = (i < 3);
            m_axi_wstrb     = (i < 3) ? 8'hFF : 8'h00;
            for (int c = 0; c < 3; c++) begin
                d_channel_ready = (c == 2);
                total++;
                if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b1, 1'b0, ea[i], es[i]})
                    $display("FAIL stall_chunk%0d_cyc%0d: vld=%b rdy=%b addr=%0d size=%0d, want 1 0 %0d %0d",
                             i, c, d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size, ea[i], es[i]);
                else passed++;
                step();
            end
        end
        s_channel_valid = 1'b0;
        d_channel_ready = 1'b0;
        total++;
        if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b0, 1'b1, 3'd0, 8'd0})
            $display("FAIL stall_idle: vld=%b rdy=%b addr=%0d size=%0d, want 0 1 0 0",
                     d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size);
        else passed++;
    endtask

    task automatic test_zero_strobe();
        d_channel_ready = 1'b1;
        load(8'h00);
        for (int c = 0; c < 2; c++) begin
            total++;
            if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b0, 1'b1, 3'd0, 8'd0})
                $display("FAIL zero_strobe%0d: vld=%b rdy=%b addr=%0d size=%0d, want 0 1 0 0",
                         c, d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size);
            else passed++;
            step();
        end
    endtask

    task automatic test_reset_mid_send();
        d_channel_ready = 1'b1;
        load(8'b0111_1110);
        step();
        d_channel_ready = 1'b0;
        total++;
        if ({d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, 3'd2, 8'd2})
            $display("FAIL rst_pre: vld=%b addr=%0d size=%0d, want 1 2 2",
                     d_channel_valid, pmesh_addr, pmesh_data_size);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size} !== {1'b0, 1'b1, 3'd0, 8'd0})
            $display("FAIL rst_mid_send: vld=%b rdy=%b addr=%0d size=%0d, want 0 1 0 0",
                     d_channel_valid, s_channel_ready, pmesh_addr, pmesh_data_size);
        else passed++;
        step();
        total++;
        if (d_channel_valid !== 1'b0)
            $display("FAIL rst_discard: vld=%b, want 0", d_channel_valid);
        else passed++;
        d_channel_ready = 1'b1;
        load(8'b0000_0001);
        total++;
        if ({d_channel_valid, pmesh_addr, pmesh_data_size} !== {1'b1, 3'd7, 8'd1})
            $display("FAIL rst_recover: vld=%b addr=%0d size=%0d, want 1 7 1",
                     d_channel_valid, pmesh_addr, pmesh_data_size);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_stall();
        test_zero_strobe();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
